vocoder_interp: RTL and testbench



---
 rtl/vocoder_pkg.sv | 24 ++
 rtl/vocoder_interp_sync_fifo.sv | 63 ++++++
 rtl/vocoder_interp.sv | 156 +++++++++++++++
 tb/tb_vocoder_interp.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vocoder_pkg.sv
// vocoder_pkg -- shared constants and types for the vocoder rate-change stages.
//   DEFAULT_WIDTH / DEFAULT_RATIO / DEFAULT_FIFO_DEPTH : default stage parameters
//   phase_w()  : width of a phase counter that counts 0..ratio-1
//   PHASE_W    : phase counter width for the default ratio
//   interp_state_e : interpolator priming state (EMPTY = no previous sample yet)
package vocoder_pkg;

  localparam int DEFAULT_WIDTH      = 3;
  localparam int DEFAULT_RATIO      = 2;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // A ratio of 1 would give a zero-width counter, so clamp to one bit.
  function automatic int phase_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  localparam int PHASE_W = phase_w(DEFAULT_RATIO);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } interp_state_e;

endpackage

// File: rtl/vocoder_interp_sync_fifo.sv
// sync_fifo -- single-clock FIFO, shared by the decimator and interpolator sides.
//   clk, rst_n (sync, active-low) : clock / reset (pointers and count only)
//   push, wr_data  : write request and data (ignored while full)
//   pop            : read request (ignored while empty)
//   rd_data        : head of the queue, combinational (undefined while empty)
//   full, empty, count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import vocoder_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  parameter int  DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; the count decides what
  // is valid, and leaving it out of reset lets it map onto plain RAM/regfile.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vocoder_interp.sv
// vocoder_interp -- restores the full sample rate after the decimate-by-2 stage.
// Input samples are buffered in a small FIFO; each consecutive pair (prev, cur)
// yields RATIO outputs prev + floor((cur - prev) * phase / RATIO).
//   clk, rst_n (sync, active-low)
//   in_valid / in_ready / in_data    : decimated sample stream (in_ready = !full)
//   out_valid / out_ready / out_data : registered full-rate stream
// Build option: define VOCODER_INTERP_ZOH_EN for zero-order hold (each input
// sample repeated RATIO times, no priming sample needed).
module vocoder_interp
  import vocoder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int RATIO      = DEFAULT_RATIO,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int SH = $clog2(RATIO);
  localparam int PW = phase_w(RATIO);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);

  logic [WIDTH-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push;
  logic             pop;

  // Space is judged on occupancy alone: a pop on the same edge never makes
  // room for a push into a full FIFO.
  assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push     = in_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  logic [PW-1:0]    phase_q;
  logic [PW-1:0]    phase_d;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_d;
  logic             out_free;
  logic             last;
  logic             fire;

  assign out_free = !out_valid || out_ready;
  assign last     = (phase_q == LAST_PHASE);

`ifndef VOCODER_INTERP_ZOH_EN
  interp_state_e          state_q;
  interp_state_e          state_d;
  logic [WIDTH-1:0]       prev_q;
  logic [WIDTH-1:0]       prev_d;
  logic signed [WIDTH:0]  diff;
  logic signed [WIDTH+SH:0] prod;
  logic signed [WIDTH+SH:0] step;
  logic [WIDTH-1:0]       interp;

  // Signed slope times phase, then an arithmetic shift so negative slopes
  // round toward minus infinity. The sum is always in range, so truncation
  // back to WIDTH bits is exact.
  always_comb begin
    diff   = $signed({1'b0, head}) - $signed({1'b0, prev_q});
    prod   = $signed({{SH{diff[WIDTH]}}, diff}) * $signed({{(WIDTH+1){1'b0}}, phase_q});
    step   = prod >>> SH;
    interp = WIDTH'($unsigned(step) + {{(SH+1){1'b0}}, prev_q});
  end
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and infers a latch.
    pop         = 1'b0;
    fire        = 1'b0;
    phase_d     = phase_q;
    out_valid_d = out_valid && !out_ready;
    out_data_d  = out_data;
`ifdef VOCODER_INTERP_ZOH_EN
    if (!fifo_empty && out_free) begin
      fire       = 1'b1;
      out_data_d = head;
    end
`else
    state_d = state_q;
    prev_d  = prev_q;
    case (state_q)
      ST_EMPTY: begin
        // Prime: the first sample only becomes the left end of a segment.
        if (!fifo_empty) begin
          pop     = 1'b1;
          prev_d  = head;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!fifo_empty && out_free) begin
          fire       = 1'b1;
          out_data_d = interp;
          if (last) prev_d = head;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
`endif
    if (fire) begin
      out_valid_d = 1'b1;
      if (last) begin
        pop     = 1'b1;
        phase_d = '0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifndef VOCODER_INTERP_ZOH_EN
      state_q   <= ST_EMPTY;
      prev_q    <= '0;
`endif
    end else begin
      phase_q   <= phase_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
`ifndef VOCODER_INTERP_ZOH_EN
      state_q   <= state_d;
      prev_q    <= prev_d;
`endif
    end
  end

endmodule

// File: tb/tb_vocoder_interp.sv
// tb_vocoder_interp -- self-checking bench for vocoder_interp.
// Two instances (RATIO=2 and RATIO=4) share one stimulus stream. A behavioural
// model turns every accepted input sample into the list of outputs it implies
// (line segments between consecutive samples, or repeated samples when
// VOCODER_INTERP_ZOH_EN is defined); every accepted output is compared against
// that list, held outputs must stay stable, and literal sequences pin the model.
`timescale 1ns/1ps
module tb_vocoder_interp;

  localparam int W     = 3;
  localparam int DEPTH = 4;
  localparam int NDUT  = 2;
  localparam int QN    = 16384;
  localparam int LOGN  = 64;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic [W-1:0]   in_data   = '0;
  logic           out_ready = 1'b0;
  logic [NDUT-1:0] in_ready_w;
  logic [NDUT-1:0] out_valid_w;
  logic [W-1:0]   out_data_w [NDUT];

  int ratio_of [NDUT] = '{2, 4};

  int n_vec  = 0;
  int n_fail = 0;

  // Model state
  logic [W-1:0] exp_mem [NDUT][QN];
  int           exp_wr [NDUT] = '{0, 0};
  int           exp_rd [NDUT] = '{0, 0};
  int           last_s [NDUT] = '{0, 0};
  bit           have_last [NDUT] = '{1'b0, 1'b0};
  logic [W-1:0] log_mem [NDUT][LOGN];
  int           log_n [NDUT] = '{0, 0};
  bit           hold_q [NDUT] = '{1'b0, 1'b0};
  logic [W-1:0] hold_d [NDUT];
  int           lit [$];

  always #5 clk = ~clk;

  vocoder_interp #(.WIDTH(W), .RATIO(2), .FIFO_DEPTH(DEPTH)) u_r2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w[0]),
    .in_data   (in_data),
    .out_valid (out_valid_w[0]),
    .out_ready (out_ready),
    .out_data  (out_data_w[0])
  );

  vocoder_interp #(.WIDTH(W), .RATIO(4), .FIFO_DEPTH(DEPTH)) u_r4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w[1]),
    .in_data   (in_data),
    .out_valid (out_valid_w[1]),
    .out_ready (out_ready),
    .out_data  (out_data_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic exp_append(input int i, input int v);
    exp_mem[i][exp_wr[i] % QN] = W'(v);
    exp_wr[i]++;
  endtask

  // Outputs implied by one accepted input sample.
  task automatic model_push(input int i, input int x);
    int r;
    r = ratio_of[i];
`ifdef VOCODER_INTERP_ZOH_EN
    for (int p = 0; p < r; p++) exp_append(i, x);
`else
    if (have_last[i])
      for (int p = 0; p < r; p++)
        exp_append(i, last_s[i] + floor_div((x - last_s[i]) * p, r));
`endif
    last_s[i]    = x;
    have_last[i] = 1'b1;
  endtask

  // Compare process: sampled mid-cycle, describing what the next edge does.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!rst_n) begin
        exp_wr[i]    = 0;
        exp_rd[i]    = 0;
        have_last[i] = 1'b0;
        last_s[i]    = 0;
        log_n[i]     = 0;
        hold_q[i]    = 1'b0;
      end else begin
        if (hold_q[i]) begin
          check($sformatf("hold_valid_r%0d", ratio_of[i]), out_valid_w[i], 1);
          check($sformatf("hold_data_r%0d", ratio_of[i]), out_data_w[i], hold_d[i]);
        end
        if (out_valid_w[i] === 1'b1 && out_ready) begin
          if (exp_rd[i] == exp_wr[i]) begin
            n_vec++;
            n_fail++;
            $display("FAIL spurious_out_r%0d: got output %0d, expected none (t=%0t)",
                     ratio_of[i], out_data_w[i], $time);
          end else begin
            check($sformatf("out_data_r%0d_#%0d", ratio_of[i], exp_rd[i]),
                  out_data_w[i], exp_mem[i][exp_rd[i] % QN]);
            exp_rd[i]++;
          end
          if (log_n[i] < LOGN) log_mem[i][log_n[i]] = out_data_w[i];
          log_n[i]++;
        end
        hold_q[i] = (out_valid_w[i] === 1'b1) && !out_ready;
        hold_d[i] = out_data_w[i];
        if (in_valid && in_ready_w[i] === 1'b1) model_push(i, int'(in_data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic push(input int x);
    in_valid = 1'b1;
    in_data  = W'(x);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic check_log(input int i, input string tag);
    check({tag, "_count"}, log_n[i], lit.size());
    for (int k = 0; k < lit.size() && k < log_n[i] && k < LOGN; k++)
      check($sformatf("%s_out%0d", tag, k), log_mem[i][k], lit[k]);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_in_ready_r%0d", tag, ratio_of[i]), in_ready_w[i], 1);
      check($sformatf("%s_out_valid_r%0d", tag, ratio_of[i]), out_valid_w[i], 0);
      check($sformatf("%s_out_data_r%0d", tag, ratio_of[i]), out_data_w[i], 0);
    end
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (exp_wr[0] == exp_rd[0] && exp_wr[1] == exp_rd[1]) break;
      tick(1);
    end
    tick(2);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_pending_r%0d", tag, ratio_of[i]), exp_wr[i] - exp_rd[i], 0);
      check($sformatf("%s_idle_r%0d", tag, ratio_of[i]), out_valid_w[i], 0);
    end
  endtask

  task automatic rand_run(input int n, input int reset_at);
    for (int c = 0; c < n; c++) begin
      int pv;
      int pr;
      pv = ((c / 400) % 3 == 0) ? 80 : (((c / 400) % 3 == 1) ? 30 : 55);
      pr = ((c / 400) % 2 == 0) ? 90 : 40;
      in_valid  = ($urandom_range(99) < pv);
      in_data   = W'($urandom_range(7));
      out_ready = ($urandom_range(99) < pr);
      if (c == reset_at) do_reset();
      else tick(1);
    end
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    check_reset_state("reset");

    // A: RATIO=2 segment sequence and first-output latency.
    out_ready = 1'b1;
    push(2);
`ifdef VOCODER_INTERP_ZOH_EN
    check("A_first_valid_pre", out_valid_w[0], 0);
`endif
    push(6);
`ifdef VOCODER_INTERP_ZOH_EN
    check("A_first_valid", out_valid_w[0], 1);
    check("A_first_data", out_data_w[0], 2);
`else
    check("A_first_valid_pre", out_valid_w[0], 0);
`endif
    push(0);
`ifndef VOCODER_INTERP_ZOH_EN
    check("A_first_valid", out_valid_w[0], 1);
    check("A_first_data", out_data_w[0], 2);
`endif
    tick(12);
`ifdef VOCODER_INTERP_ZOH_EN
    lit = '{2, 2, 6, 6, 0, 0};
`else
    lit = '{2, 4, 6, 3};
`endif
    check_log(0, "A_r2");

    // B: RATIO=4 rising then falling slope (floor on the way down).
    do_reset();
    push(0);
    push(7);
    push(0);
    tick(16);
`ifdef VOCODER_INTERP_ZOH_EN
    lit = '{0, 0, 0, 0, 7, 7, 7, 7, 0, 0, 0, 0};
`else
    lit = '{0, 1, 3, 5, 7, 5, 3, 1};
`endif
    check_log(1, "B_r4");

    // C: downstream stall fills the FIFO; held data must stay put.
    do_reset();
    out_ready = 1'b0;
    for (int s = 1; s <= 5; s++) push(s);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("C_full_in_ready_r%0d", ratio_of[i]), in_ready_w[i], 0);
    in_valid = 1'b1;
    in_data  = 3'd7;
    tick(5);
    drain("C");

    // D: input gap, then resume.
    do_reset();
    out_ready = 1'b1;
    push(1);
    push(5);
    push(3);
    tick(16);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("D_gap_idle_r%0d", ratio_of[i]), out_valid_w[i], 0);
    push(6);
    drain("D");

    // E: reset in the middle of traffic, then a single priming push.
    do_reset();
    rand_run(60, -1);
    out_ready = 1'b1;
    do_reset();
    check_reset_state("E_reset");
    push(4);
    tick(6);
    for (int i = 0; i < NDUT; i++) begin
`ifdef VOCODER_INTERP_ZOH_EN
      check($sformatf("E_after_one_push_r%0d", ratio_of[i]), log_n[i], ratio_of[i]);
`else
      check($sformatf("E_after_one_push_r%0d", ratio_of[i]), log_n[i], 0);
`endif
    end

    // F: long randomized run with a reset partway through.
    rand_run(3000, 1700);
    drain("F");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
